// File: rtl/tri_pkg.sv
// Shared definitions for the triangle record loader: default geometry,
// controller state encoding and vertex/component slot indices.
package tri_pkg;

  localparam int WORD_W_DEF    = 16;
  localparam int NUM_WORDS_DEF = 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    HOLD = 2'd2
  } tri_state_e;

  // Slot k of the record: vertex v, component c -> k = 3*v + c
  localparam int VX0 = 0;
  localparam int VY0 = 1;
  localparam int VZ0 = 2;
  localparam int VX1 = 3;
  localparam int VY1 = 4;
  localparam int VZ1 = 5;
  localparam int VX2 = 6;
  localparam int VY2 = 7;
  localparam int VZ2 = 8;

  // Slot index of component comp (0=x,1=y,2=z) of vertex vtx
  function automatic int slot_idx(input int vtx, input int comp);
    return vtx * 3 + comp;
  endfunction

endpackage

// File: rtl/tri_bit_shifter.sv
// Serial-to-parallel word assembler: collects WORD_W bits MSB first and
// pulses o_word_done on the strobe that carries the final bit, presenting
// the completed word on o_word in that same cycle.
module tri_bit_shifter
  import tri_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr,
  input  logic              i_shift,
  input  logic              i_bit,
  output logic [WORD_W-1:0] o_word,
  output logic              o_word_done
);

  localparam int BC_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  // Only the WORD_W-1 earlier bits need storing; the last bit of a word
  // is taken straight from the serial input when the word completes.
  logic [WORD_W-2:0] r_shift;
  logic [BC_W-1:0]   r_bit_cnt;
  logic              w_last_bit;

  assign w_last_bit  = (r_bit_cnt == BC_W'(WORD_W - 1));
  assign o_word      = {r_shift, i_bit};
  assign o_word_done = i_shift && w_last_bit;

  // Shift in one bit per strobe and count bit position within the word
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
    end else begin
      if (i_shift) begin
        r_shift <= o_word[WORD_W-2:0];
      end
      if (i_clr) begin
        r_bit_cnt <= '0;
      end else if (i_shift) begin
        r_bit_cnt <= w_last_bit ? '0 : r_bit_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/tri_load_ctrl.sv
// Triangle record loader: arms on start, assembles NUM_WORDS serial words
// into a parallel record, holds it under a valid/ready handshake and flags
// serial strobes that arrive while not receiving (sticky overrun).
// Optional build macro TRI_CHECKSUM_EN: an extra XOR checksum word follows
// the data words and a mismatch is reported on tri_err.
module tri_load_ctrl
  import tri_pkg::*;
#(
  parameter int WORD_W    = WORD_W_DEF,
  parameter int NUM_WORDS = NUM_WORDS_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ser_in,
  input  logic                        ser_en,
  input  logic                        start,
  input  logic                        tri_ready,
  output logic                        tri_valid,
  output logic [NUM_WORDS*WORD_W-1:0] tri_data,
  output logic                        tri_err,
  output logic                        busy,
  output logic                        overrun
);

  localparam int WC_W = $clog2(NUM_WORDS + 1);

`ifdef TRI_CHECKSUM_EN
  localparam int LAST_IDX = NUM_WORDS;      // checksum word follows the data
`else
  localparam int LAST_IDX = NUM_WORDS - 1;
`endif

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_RECV = RECV;
  localparam logic [1:0] ST_HOLD = HOLD;

  logic [1:0]                  r_state;
  logic [WC_W-1:0]             r_word_cnt;
  logic [NUM_WORDS*WORD_W-1:0] r_data;
  logic                        r_overrun;

  logic              w_shift;
  logic              w_clr;
  logic              w_handshake;
  logic              w_word_done;
  logic              w_last_word;
  logic [WORD_W-1:0] w_word;

  assign w_shift     = ser_en && (r_state == ST_RECV);
  assign w_handshake = (r_state == ST_HOLD) && tri_ready;
  // Counters restart whenever a new capture is armed, including the
  // back-to-back case where the handshake and start share a cycle.
  assign w_clr       = start && ((r_state == ST_IDLE) || w_handshake);
  assign w_last_word = w_word_done && (r_word_cnt == WC_W'(LAST_IDX));

  tri_bit_shifter #(
    .WORD_W (WORD_W)
  ) u_shifter (
    .clk         (clk),
    .rst         (rst),
    .i_clr       (w_clr),
    .i_shift     (w_shift),
    .i_bit       (ser_in),
    .o_word      (w_word),
    .o_word_done (w_word_done)
  );

  // Controller state: arm, receive, hold until accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (start)       r_state <= ST_RECV;
        ST_RECV: if (w_last_word) r_state <= ST_HOLD;
        ST_HOLD: if (w_handshake) r_state <= start ? ST_RECV : ST_IDLE;
        default:                  r_state <= ST_IDLE;
      endcase
    end
  end

  // Word index within the record; frozen on the final word so it never
  // needs a value beyond NUM_WORDS
  always_ff @(posedge clk) begin
    if (rst) begin
      r_word_cnt <= '0;
    end else if (w_clr) begin
      r_word_cnt <= '0;
    end else if (w_word_done && !w_last_word) begin
      r_word_cnt <= r_word_cnt + 1'b1;
    end
  end

  // Write each completed data word into its slot; old slots persist until
  // overwritten by the next capture
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data <= '0;
    end else if (w_word_done) begin
      for (int k = 0; k < NUM_WORDS; k++) begin
        if (r_word_cnt == WC_W'(k)) begin
          r_data[k*WORD_W +: WORD_W] <= w_word;
        end
      end
    end
  end

  // Sticky flag for strobes that arrive outside RECV; those bits are dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overrun <= 1'b0;
    end else if (ser_en && (r_state != ST_RECV)) begin
      r_overrun <= 1'b1;
    end
  end

`ifdef TRI_CHECKSUM_EN
  logic [WORD_W-1:0] r_csum;
  logic              r_err;

  // Running XOR of data words; compare with the checksum word at its end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_csum <= '0;
      r_err  <= 1'b0;
    end else begin
      if (w_clr) begin
        r_csum <= '0;
      end else if (w_word_done && (r_word_cnt < WC_W'(NUM_WORDS))) begin
        r_csum <= r_csum ^ w_word;
      end
      if (w_last_word) begin
        r_err <= (r_csum != w_word);
      end
    end
  end

  assign tri_err = r_err;
`else
  assign tri_err = 1'b0;
`endif

  assign tri_valid = (r_state == ST_HOLD);
  assign busy      = (r_state == ST_RECV) || (r_state == ST_HOLD);
  assign tri_data  = r_data;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_tri_load_ctrl.sv
// Scoreboard bench for tri_load_ctrl: stimulus pushes the expected record
// when a capture starts; a negedge monitor pops and compares on each new
// tri_valid assertion.
module tb_tri_load_ctrl;

  localparam int WW = 16;
  localparam int NW = 9;
  localparam int DW = WW * NW;
`ifdef TRI_CHECKSUM_EN
  localparam bit CSUM_ON = 1'b1;
`else
  localparam bit CSUM_ON = 1'b0;
`endif

  typedef struct packed {
    logic [DW-1:0] data;
    logic          err;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          ser_in;
  logic          ser_en;
  logic          start;
  logic          tri_ready;
  logic          tri_valid;
  logic [DW-1:0] tri_data;
  logic          tri_err;
  logic          busy;
  logic          overrun;

  int            errors = 0;
  int            checks = 0;
  exp_t          sb[$];
  exp_t          mon_e;
  bit            seen = 1'b0;
  logic [WW-1:0] rec[NW];
  int            early_valid;
  int            bad;
  logic [DW-1:0] expd;

  always #5 clk = ~clk;

  tri_load_ctrl #(
    .WORD_W    (WW),
    .NUM_WORDS (NW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ser_in    (ser_in),
    .ser_en    (ser_en),
    .start     (start),
    .tri_ready (tri_ready),
    .tri_valid (tri_valid),
    .tri_data  (tri_data),
    .tri_err   (tri_err),
    .busy      (busy),
    .overrun   (overrun)
  );

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic checkd(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compare each newly presented record against the scoreboard
  always @(negedge clk) begin
    if (rst || !tri_valid) begin
      seen = 1'b0;
    end else if (!seen) begin
      seen = 1'b1;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_record: got %h expected none", tri_data);
      end else begin
        mon_e = sb.pop_front();
        checkd("record_data", tri_data, mon_e.data);
        check1("record_err", tri_err, mon_e.err);
      end
    end
  end

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] pack_rec();
    logic [DW-1:0] d;
    d = '0;
    for (int k = 0; k < NW; k++) d[k*WW +: WW] = rec[k];
    return d;
  endfunction

  task automatic send_word(input logic [WW-1:0] w, input bit gapped);
    for (int i = WW - 1; i >= 0; i--) begin
      if (gapped) begin
        ser_en = 1'b0;
        tick();
      end
      ser_en = 1'b1;
      ser_in = w[i];
      if (tri_valid) early_valid++;
      tick();
    end
    ser_en = 1'b0;
    ser_in = 1'b0;
  endtask

  task automatic send_record(input bit gapped, input logic [WW-1:0] csum, input logic err_if_en);
    exp_t e;
    e.data = pack_rec();
    e.err  = err_if_en & CSUM_ON;
    sb.push_back(e);
    early_valid = 0;
    for (int k = 0; k < NW; k++) send_word(rec[k], gapped);
    if (CSUM_ON) send_word(csum, gapped);
    check1("valid_latency", tri_valid, 1'b1);
    check1("no_early_valid", early_valid == 0, 1'b1);
  endtask

  task automatic arm();
    start = 1'b1;
    tick();
    start = 1'b0;
    check1("busy_after_start", busy, 1'b1);
  endtask

  task automatic accept(input bit st);
    tri_ready = 1'b1;
    start     = st;
    tick();
    tri_ready = 1'b0;
    start     = 1'b0;
    check1("valid_drop_on_handshake", tri_valid, 1'b0);
    check1("busy_after_handshake", busy, st);
  endtask

  initial begin
    rst = 1'b1; ser_in = 1'b0; ser_en = 1'b0; start = 1'b0; tri_ready = 1'b0;
    repeat (3) tick();
    check1("reset_valid", tri_valid, 1'b0);
    check1("reset_busy", busy, 1'b0);
    check1("reset_overrun", overrun, 1'b0);
    check1("reset_err", tri_err, 1'b0);
    checkd("reset_data", tri_data, '0);
    rst = 1'b0;
    tick();

    // Basic contiguous load of words 1..9 (XOR checksum 0x0001)
    for (int k = 0; k < NW; k++) rec[k] = WW'(k + 1);
    arm();
    send_record(1'b0, 16'h0001, 1'b0);
    check1("busy_in_hold", busy, 1'b1);
    accept(1'b0);

    // Gapped strobes, same words, wrong checksum
    arm();
    send_record(1'b1, 16'h0000, 1'b1);
    accept(1'b0);

    // Backpressure: record must stay stable for 20 cycles
    arm();
    send_record(1'b0, 16'h0001, 1'b0);
    expd = pack_rec();
    bad = 0;
    repeat (20) begin
      tick();
      if (!tri_valid || tri_data !== expd) bad++;
    end
    check1("backpressure_stable", bad == 0, 1'b1);

    // Back-to-back: accept with start, then all-0xA5A5 record
    for (int k = 0; k < NW; k++) rec[k] = 16'hA5A5;
    accept(1'b1);
    check1("no_overrun_yet", overrun, 1'b0);
    send_record(1'b0, 16'hA5A5, 1'b0);

    // Overrun during HOLD, in IDLE, and together with start
    ser_en = 1'b1; ser_in = 1'b1;
    tick();
    ser_en = 1'b0; ser_in = 1'b0;
    check1("overrun_hold", overrun, 1'b1);
    accept(1'b0);
    ser_en = 1'b1; ser_in = 1'b1;
    tick();
    ser_en = 1'b0; ser_in = 1'b0;
    tick();
    check1("overrun_idle_sticky", overrun, 1'b1);
    for (int k = 0; k < NW; k++) rec[k] = WW'(16'h0100 + k);
    start = 1'b1; ser_en = 1'b1; ser_in = 1'b1;
    tick();
    start = 1'b0; ser_en = 1'b0; ser_in = 1'b0;
    check1("busy_after_start_strobe", busy, 1'b1);
    send_record(1'b0, 16'h0108, 1'b0);
    check1("overrun_still_set", overrun, 1'b1);
    accept(1'b0);

    // Reset after five words aborts the capture
    for (int k = 0; k < NW; k++) rec[k] = WW'(k + 1);
    arm();
    for (int k = 0; k < 5; k++) send_word(rec[k], 1'b0);
    rst = 1'b1;
    tick();
    check1("midrst_valid", tri_valid, 1'b0);
    check1("midrst_busy", busy, 1'b0);
    check1("midrst_overrun", overrun, 1'b0);
    check1("midrst_err", tri_err, 1'b0);
    checkd("midrst_data", tri_data, '0);
    rst = 1'b0;
    tick();
    arm();
    send_record(1'b0, 16'h0001, 1'b0);
    accept(1'b0);

    repeat (5) tick();
    check1("scoreboard_drained", sb.size() == 0, 1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
